alu4b_input_seq: RTL
====================

// Module: alu4b_input_seq
// PURPOSE
//  Operand/opcode entry sequencer upstream of alu4b on the lab board.
//  - Loads A, B and the opcode {s1,s0} one at a time from 4 slide switches,
//    stepped by one push button.
//  - Raises valid once all three are held. a/b/s0/s1 wire straight to the alu4b inputs.
//  - Button and switches are synchronized. The button is also debounced and edge-detected.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable synchronized samples needed to accept a button level (>=2)
//  CNT_W  derived localparam = $clog2(DEBOUNCE_CYCLES), not overridable
// PORTS
//  clk    in   1  system clock, rising edge
//  rst_n  in   1  asynchronous, active-low reset
//  sw     in   4  raw slide switches: data nibble (A, B) or opcode in sw[1:0]
//  btn    in   1  raw push button, active-high, bouncy
//  clr    in   1  raw clear request, active-high level
//  a      out  4  operand A to alu4b
//  b      out  4  operand B to alu4b
//  s0     out  1  opcode bit 0 to alu4b
//  s1     out  1  opcode bit 1 to alu4b
//  valid  out  1  1 = a, b, s1, s0 complete; alu4b result is meaningful
//  state  out  2  current FSM state, for LEDs
// BEHAVIOUR
//  Reset
//   - rst_n=0 immediately forces: a=0, b=0, s0=0, s1=0, valid=0, state=LOAD_A.
//   - All synchronizer flops, the debounced level and the counter also go to 0.
//   - This applies in any state, mid-sequence included.
//  Synchronization
//   - btn, clr and sw each pass through two flops.
//   - Only the synchronized values are used internally.
//  Debounce
//   - Keep a debounced level deb and a counter cnt.
//   - Synchronized btn == deb: cnt<=0.
//   - Differs and cnt < DEBOUNCE_CYCLES-1: cnt<=cnt+1.
//   - Differs and cnt == DEBOUNCE_CYCLES-1: deb<=synchronized btn, cnt<=0.
//   - press is a registered 1-cycle pulse, set when deb goes 0->1.
//   - Timing: btn high from sampling edge 0 gives press high after edge D+1.
//     The target register updates on edge D+2 (D=DEBOUNCE_CYCLES).
//   - Glitches shorter than D stable samples never toggle deb.
//   - Holding btn produces exactly one press. No auto-repeat.
//  FSM (state encoding)
//   - LOAD_A=00, LOAD_B=01, LOAD_OP=10, SHOW=11.
//   - LOAD_A  + press: a<=sw_sync;               go to LOAD_B
//   - LOAD_B  + press: b<=sw_sync;               go to LOAD_OP
//   - LOAD_OP + press: {s1,s0}<=sw_sync[1:0];    go to SHOW. sw_sync[3:2] ignored.
//   - SHOW    + press: go to LOAD_A. a, b, s0, s1 hold until overwritten.
//   - No press: state and data registers hold.
//  valid
//   - Registered. Equals (state==SHOW).
//   - Rises on the same edge that captures the opcode.
//   - Falls on the same edge that leaves SHOW.
//  Opcodes
//   - 00 soma, 01 subtracao, 10 AND, 11 OR. Matches the alu4b s1/s0 decode.
//  clr
//   - Synchronized clr=1 on an edge: state<=LOAD_A, valid<=0. Data registers hold.
//   - clr has priority over press on the same edge; that press is discarded.
//   - clr is not debounced; its action is idempotent.
//  Other rules
//   - No arithmetic on the data path. Registers are loaded verbatim.
// STRUCTURE
//  - Shared include alu4b_defs.vh holds:
//    - state codes ST_LOAD_A/ST_LOAD_B/ST_LOAD_OP/ST_SHOW
//    - opcodes OP_SOM=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
//    - alu4b uses the same file.
//  - One sub-module, btn_debounce, parameterized by DEBOUNCE_CYCLES:
//    - 2-flop synchronizer, counter, deb level and registered rising-edge press pulse.
//  - Top level: sw/clr synchronizers, FSM, data registers.
// TESTING (DEBOUNCE_CYCLES=4, bench drives btn clean unless stated)
//  1. Full sequence: sw=1010 press, sw=0110 press, sw=0001 press
//     -> a=1010, b=0110, s1s0=01, valid=1, state=11.
//     -> Chained alu4b shows 4 with cout_sub consistent.
//  2. Latency: btn rises just before edge 0, held
//     -> press high after edge 5; a updated on edge 6; state=01 after edge 6.
//  3. Bounce: btn high pulses of 1, 2, 3 cycles separated by 1 low
//     -> no state change. Then held 10 cycles -> exactly one advance.
//  4. Long hold: btn high 100 cycles in LOAD_A
//     -> single advance to LOAD_B. Release 8 cycles and press -> LOAD_OP.
//  5. SHOW then press -> state=00, valid=0, a=1010, b=0110, s1s0=01 retained.
//  6. Reset/clr:
//     -> rst_n low mid-LOAD_OP: all outputs 0 without waiting for a clk edge.
//     -> clr and press on the same edge in LOAD_B: state=00, b unchanged.

Source files
------------

// File: rtl/alu4b_input_seq_pkg.sv
// alu4b_input_seq_pkg: shared state codes, opcodes and defaults for the alu4b entry sequencer
package alu4b_input_seq_pkg;
  typedef enum logic [1:0] {LOAD_A = 2'b00, LOAD_B = 2'b01, LOAD_OP = 2'b10, SHOW = 2'b11} state_t;
  typedef enum logic [1:0] {OP_SOM = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} op_t;
  localparam int DEBOUNCE_DEFAULT = 4;
endpackage

// File: rtl/alu4b_input_seq_if.sv
// alu4b_input_seq_if: board-side inputs and alu4b-side outputs of the entry sequencer
interface alu4b_input_seq_if;
  import alu4b_input_seq_pkg::*;
  logic [3:0] sw;
  logic btn;
  logic clr;
  logic [3:0] a;
  logic [3:0] b;
  logic s0;
  logic s1;
  logic valid;
  state_t state;
  modport master (output sw, btn, clr, input a, b, s0, s1, valid, state);
  modport slave (input sw, btn, clr, output a, b, s0, s1, valid, state);
endinterface

// File: rtl/alu4b_input_seq_btn_debounce.sv
// alu4b_input_seq_btn_debounce: synchronizes and debounces the push button, emits one press pulse per accepted rise
module alu4b_input_seq_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic btn_m, btn_s, deb;
  logic [CNT_W-1:0] cnt;
  // press is raised on the same edge deb rises so the FSM acts one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      press <= 1'b0;
      if (btn_s == deb) cnt <= '0;
      else if (cnt == LAST) begin
        deb   <= btn_s;
        cnt   <= '0;
        press <= btn_s;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu4b_input_seq.sv
// alu4b_input_seq: loads A, B and opcode from slide switches one press at a time and flags valid when complete
module alu4b_input_seq
  import alu4b_input_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  alu4b_input_seq_if.slave bus
);
  logic [3:0] sw_m, sw_s, a, b;
  logic clr_m, clr_s, press, s0, s1, valid;
  state_t st;
  alu4b_input_seq_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn),
    .press (press)
  );
  // states advance in encoding order LOAD_A..SHOW then wrap; clr wins over press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m  <= '0;
      sw_s  <= '0;
      clr_m <= 1'b0;
      clr_s <= 1'b0;
      a     <= '0;
      b     <= '0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      valid <= 1'b0;
      st    <= LOAD_A;
    end else begin
      sw_m  <= bus.sw;
      sw_s  <= sw_m;
      clr_m <= bus.clr;
      clr_s <= clr_m;
      if (clr_s) begin
        st    <= LOAD_A;
        valid <= 1'b0;
      end else if (press) begin
        if (st == LOAD_A) a <= sw_s;
        if (st == LOAD_B) b <= sw_s;
        if (st == LOAD_OP) {s1, s0} <= sw_s[1:0];
        st    <= state_t'(st + 2'd1);
        valid <= st == LOAD_OP;
      end
    end
  end
  assign bus.a     = a;
  assign bus.b     = b;
  assign bus.s0    = s0;
  assign bus.s1    = s1;
  assign bus.valid = valid;
  assign bus.state = st;
endmodule
